// File: rtl/difftest_trap_gen.sv
// rtl/difftest_trap_gen.sv - difftest trap-event producer: commit counters, trap-instruction detect, watchdogs
//
// Ports:
//   clock, reset          core clock, asynchronous active-high reset
//   commit_valid          per-port commit valid (COMMIT_WIDTH)
//   commit_instr          per-port instruction, port i at [32i+31:32i]
//   commit_pc             per-port PC, port i at [64i+63:64i]
//   commit_nfused         per-port count of extra fused instructions
//   a0_value              architectural x10, valid alongside the commit
//   wfi_active            core is sleeping in WFI
//   max_instr             instruction limit, 0 disables
//   coreid                static core id
//   io_enable             sink enable, high from the first edge after reset
//   io_hasTrap            one-cycle trap pulse
//   io_cycleCnt           cycles counted while running
//   io_instrCnt           instructions retired
//   io_hasWFI             wfi_active delayed by one cycle
//   io_code               trap code (0/1 trap instr, 2 stall, 3 limit)
//   io_pc                 trap PC
//   io_coreid             pass-through of coreid

module difftest_trap_gen #(
  parameter int unsigned COMMIT_WIDTH = 6,
  parameter logic [31:0] TRAP_INSTR   = 32'h0000006b,
  parameter int unsigned STALL_LIMIT  = 5000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMIT_WIDTH-1:0]   commit_valid,
  input  logic [32*COMMIT_WIDTH-1:0] commit_instr,
  input  logic [64*COMMIT_WIDTH-1:0] commit_pc,
  input  logic [8*COMMIT_WIDTH-1:0] commit_nfused,
  input  logic [63:0]               a0_value,
  input  logic                      wfi_active,
  input  logic [63:0]               max_instr,
  input  logic [7:0]                coreid,
  output logic                      io_enable,
  output logic                      io_hasTrap,
  output logic [63:0]               io_cycleCnt,
  output logic [63:0]               io_instrCnt,
  output logic                      io_hasWFI,
  output logic [2:0]                io_code,
  output logic [63:0]               io_pc,
  output logic [7:0]                io_coreid
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_TRAP = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] STALL_LIM = 32'(STALL_LIMIT);
  localparam bit          STALL_EN  = (STALL_LIMIT != 0);

  localparam logic [2:0] CODE_GOOD  = 3'd0;
  localparam logic [2:0] CODE_BAD   = 3'd1;
  localparam logic [2:0] CODE_STALL = 3'd2;
  localparam logic [2:0] CODE_LIMIT = 3'd3;

  logic [1:0]  state;
  logic        enable_q;
  logic        has_trap_q;
  logic [63:0] cycle_cnt;
  logic [63:0] instr_cnt;
  logic        has_wfi_q;
  logic [2:0]  code_q;
  logic [63:0] pc_q;
  logic [31:0] stall_cnt;
  logic [63:0] last_pc;

  // Commit-port scan results
  logic        trap_hit;
  logic [63:0] trap_pc;
  logic [63:0] instr_add;
  logic        any_counted;
  logic [63:0] last_pc_next;
  logic        blocked;

  logic        any_valid;
  logic [63:0] instr_next;
  logic [31:0] stall_inc;
  logic [31:0] stall_next;
  logic        limit_hit;
  logic        stall_hit;

  // Ports are scanned low to high. The first valid trap instruction is
  // itself counted, then blocks every higher port in the same cycle.
  always_comb begin
    trap_hit     = 1'b0;
    trap_pc      = '0;
    instr_add    = '0;
    any_counted  = 1'b0;
    last_pc_next = last_pc;
    blocked      = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i] && !blocked) begin
        instr_add    = instr_add + 64'd1 + {56'd0, commit_nfused[8*i +: 8]};
        last_pc_next = commit_pc[64*i +: 64];
        any_counted  = 1'b1;
        if (commit_instr[32*i +: 32] == TRAP_INSTR) begin
          blocked  = 1'b1;
          trap_hit = 1'b1;
          trap_pc  = commit_pc[64*i +: 64];
        end
      end
    end
  end

  assign any_valid  = |commit_valid;
  assign instr_next = instr_cnt + instr_add;
  assign stall_inc  = stall_cnt + 32'd1;

  // WFI freezes the stall counter rather than clearing it.
  always_comb begin
    stall_next = stall_inc;
    if (any_valid) begin
      stall_next = '0;
    end else if (wfi_active) begin
      stall_next = stall_cnt;
    end
  end

  assign limit_hit = (max_instr != 64'd0) && (instr_next >= max_instr);
  assign stall_hit = STALL_EN && !any_valid && !wfi_active && (stall_inc == STALL_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      enable_q   <= 1'b0;
      has_trap_q <= 1'b0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      has_wfi_q  <= 1'b0;
      code_q     <= '0;
      pc_q       <= '0;
      stall_cnt  <= '0;
      last_pc    <= '0;
    end else begin
      enable_q  <= 1'b1;
      has_wfi_q <= wfi_active;
      case (state)
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + 64'd1;
          instr_cnt <= instr_next;
          stall_cnt <= stall_next;
          if (any_counted) begin
            last_pc <= last_pc_next;
          end
          if (trap_hit) begin
            state      <= ST_TRAP;
            has_trap_q <= 1'b1;
            code_q     <= (a0_value == 64'd0) ? CODE_GOOD : CODE_BAD;
            pc_q       <= trap_pc;
          end else if (limit_hit) begin
            state      <= ST_TRAP;
            has_trap_q <= 1'b1;
            code_q     <= CODE_LIMIT;
            pc_q       <= last_pc_next;
          end else if (stall_hit) begin
            state      <= ST_TRAP;
            has_trap_q <= 1'b1;
            code_q     <= CODE_STALL;
            pc_q       <= last_pc;
          end else begin
            has_trap_q <= 1'b0;
          end
        end
        ST_TRAP: begin
          state      <= ST_HALT;
          has_trap_q <= 1'b0;
        end
        default: begin
          // HALT, and any unused encoding, parks until reset
          state      <= ST_HALT;
          has_trap_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_enable   = enable_q;
  assign io_hasTrap  = has_trap_q;
  assign io_cycleCnt = cycle_cnt;
  assign io_instrCnt = instr_cnt;
  assign io_hasWFI   = has_wfi_q;
  assign io_code     = code_q;
  assign io_pc       = pc_q;
  assign io_coreid   = coreid;

endmodule

// File: tb/tb_difftest_trap_gen.sv
// tb/tb_difftest_trap_gen.sv - self-checking bench for difftest_trap_gen
module tb_difftest_trap_gen;

  localparam int CW = 6;
  localparam logic [31:0] TRAP = 32'h0000006b;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [CW-1:0]    commit_valid;
  logic [32*CW-1:0] commit_instr;
  logic [64*CW-1:0] commit_pc;
  logic [8*CW-1:0]  commit_nfused;
  logic [63:0]      a0_value;
  logic             wfi_active;
  logic [63:0]      max_instr;
  logic [7:0]       coreid;

  logic        d0_en, d0_ht, d0_wfi, d1_en, d1_ht, d1_wfi;
  logic [63:0] d0_cyc, d0_ins, d0_pc, d1_cyc, d1_ins, d1_pc;
  logic [2:0]  d0_code, d1_code;
  logic [7:0]  d0_cid, d1_cid;

  difftest_trap_gen dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_instr(commit_instr),
    .commit_pc(commit_pc), .commit_nfused(commit_nfused), .a0_value(a0_value),
    .wfi_active(wfi_active), .max_instr(max_instr), .coreid(coreid),
    .io_enable(d0_en), .io_hasTrap(d0_ht), .io_cycleCnt(d0_cyc), .io_instrCnt(d0_ins),
    .io_hasWFI(d0_wfi), .io_code(d0_code), .io_pc(d0_pc), .io_coreid(d0_cid)
  );

  difftest_trap_gen #(.STALL_LIMIT(8)) dut_s (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_instr(commit_instr),
    .commit_pc(commit_pc), .commit_nfused(commit_nfused), .a0_value(a0_value),
    .wfi_active(wfi_active), .max_instr(max_instr), .coreid(coreid),
    .io_enable(d1_en), .io_hasTrap(d1_ht), .io_cycleCnt(d1_cyc), .io_instrCnt(d1_ins),
    .io_hasWFI(d1_wfi), .io_code(d1_code), .io_pc(d1_pc), .io_coreid(d1_cid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = running, 1 = trap pulse, 2 = halted
  int          m_phase[2];
  logic [63:0] m_cyc[2], m_ins[2], m_last[2], m_pc[2];
  int unsigned m_st[2];
  logic [2:0]  m_code[2];
  bit          m_ht[2], m_wfi[2], m_en[2];

  function automatic int unsigned lim(input int k);
    return (k == 0) ? 5000 : 8;
  endfunction

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_cyc[k] = 0; m_ins[k] = 0; m_last[k] = 0; m_pc[k] = 0;
    m_st[k] = 0; m_code[k] = 0; m_ht[k] = 0; m_wfi[k] = 0; m_en[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit          found;
    logic [63:0] tpc, sum;
    found = 0; tpc = 0; sum = 0;
    m_en[k] = 1;
    m_wfi[k] = wfi_active;
    if (m_phase[k] == 0) begin
      m_cyc[k] = m_cyc[k] + 64'd1;
      for (int i = 0; i < CW; i++) begin
        if (commit_valid[i]) begin
          sum = sum + 64'd1 + 64'(commit_nfused[8*i +: 8]);
          m_last[k] = commit_pc[64*i +: 64];
          if (commit_instr[32*i +: 32] == TRAP) begin
            found = 1;
            tpc = commit_pc[64*i +: 64];
            break;
          end
        end
      end
      m_ins[k] = m_ins[k] + sum;
      if (commit_valid != 0) m_st[k] = 0;
      else if (!wfi_active) m_st[k] = m_st[k] + 1;
      if (found) begin
        m_ht[k] = 1; m_code[k] = (a0_value != 0) ? 3'd1 : 3'd0; m_pc[k] = tpc; m_phase[k] = 1;
      end else if (max_instr != 0 && m_ins[k] >= max_instr) begin
        m_ht[k] = 1; m_code[k] = 3'd3; m_pc[k] = m_last[k]; m_phase[k] = 1;
      end else if (lim(k) != 0 && commit_valid == 0 && !wfi_active && m_st[k] == lim(k)) begin
        m_ht[k] = 1; m_code[k] = 3'd2; m_pc[k] = m_last[k]; m_phase[k] = 1;
      end else begin
        m_ht[k] = 0;
      end
    end else begin
      m_ht[k] = 0;
      m_phase[k] = 2;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int k, input logic en, input logic ht, input logic [63:0] cyc,
                     input logic [63:0] ins, input logic wfi, input logic [2:0] code,
                     input logic [63:0] pc, input logic [7:0] cid);
    chk($sformatf("d%0d.enable", k), 64'(en), 64'(m_en[k]));
    chk($sformatf("d%0d.hasTrap", k), 64'(ht), 64'(m_ht[k]));
    chk($sformatf("d%0d.cycleCnt", k), cyc, m_cyc[k]);
    chk($sformatf("d%0d.instrCnt", k), ins, m_ins[k]);
    chk($sformatf("d%0d.hasWFI", k), 64'(wfi), 64'(m_wfi[k]));
    chk($sformatf("d%0d.code", k), 64'(code), 64'(m_code[k]));
    chk($sformatf("d%0d.pc", k), pc, m_pc[k]);
    chk($sformatf("d%0d.coreid", k), 64'(cid), 64'(coreid));
  endtask

  always @(negedge clock) begin
    if (cmp_on && !reset) begin
      cmp(0, d0_en, d0_ht, d0_cyc, d0_ins, d0_wfi, d0_code, d0_pc, d0_cid);
      cmp(1, d1_en, d1_ht, d1_cyc, d1_ins, d1_wfi, d1_code, d1_pc, d1_cid);
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic clear_commit;
    commit_valid = '0; commit_instr = '0; commit_pc = '0; commit_nfused = '0; a0_value = '0;
  endtask

  task automatic set_port(input int i, input logic [31:0] ins, input logic [63:0] pc, input logic [7:0] nf);
    commit_valid[i] = 1'b1;
    commit_instr[32*i +: 32] = ins;
    commit_pc[64*i +: 64] = pc;
    commit_nfused[8*i +: 8] = nf;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    cmp_on = 1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".enable"}, 64'(d0_en), 64'd0);
    chk({tag, ".hasTrap"}, 64'(d0_ht | d1_ht), 64'd0);
    chk({tag, ".cycleCnt"}, d0_cyc | d1_cyc, 64'd0);
    chk({tag, ".instrCnt"}, d0_ins | d1_ins, 64'd0);
    chk({tag, ".code"}, 64'(d0_code | d1_code), 64'd0);
    chk({tag, ".pc"}, d0_pc | d1_pc, 64'd0);
    chk({tag, ".hasWFI"}, 64'(d0_wfi | d1_wfi), 64'd0);
  endtask

  // Ticks until the stall-limited instance pulses; wfi held for ticks [wf, wt)
  task automatic measure(input int wf, input int wt, output int n);
    bit found;
    found = 0; n = 0;
    while (n < 200 && !found) begin
      wfi_active = (n >= wf && n < wt);
      tick;
      n++;
      if (d1_ht) found = 1;
    end
    wfi_active = 1'b0;
    if (!found) begin
      errors++; checks++;
      $display("FAIL stall_wait: no trap within 200 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_commit();
    wfi_active = 1'b0; max_instr = '0; coreid = 8'h3;
    #1 reset = 1'b1;
    #1 check_zero("reset");
    chk("reset.coreid", 64'(d0_cid), 64'h3);
    do_reset();

    // 1: trap instruction after 10 idle cycles, good trap
    repeat (10) tick;
    set_port(0, TRAP, 64'h80000100, 8'd0);
    tick;
    clear_commit();
    chk("t1.hasTrap", 64'(d0_ht), 64'd1);
    chk("t1.code", 64'(d0_code), 64'd0);
    chk("t1.pc", d0_pc, 64'h80000100);
    chk("t1.cycleCnt", d0_cyc, 64'd11);
    chk("t1.instrCnt", d0_ins, 64'd1);
    tick;
    chk("t1.pulse_end", 64'(d0_ht), 64'd0);
    repeat (5) tick;
    chk("t1.frozen_cyc", d0_cyc, 64'd11);
    chk("t1.frozen_ins", d0_ins, 64'd1);

    // 2: trap on port 1 blocks ports 2,3; port 0 fused
    do_reset();
    set_port(0, NOP, 64'h3000, 8'd1);
    set_port(1, TRAP, 64'h3004, 8'd0);
    set_port(2, NOP, 64'h3008, 8'd0);
    set_port(3, NOP, 64'h300c, 8'd2);
    a0_value = 64'd5;
    tick;
    clear_commit();
    chk("t2.hasTrap", 64'(d0_ht), 64'd1);
    chk("t2.instrCnt", d0_ins, 64'd3);
    chk("t2.code", 64'(d0_code), 64'd1);
    chk("t2.pc", d0_pc, 64'h3004);

    // 3: instruction limit, then same-cycle trap instruction wins
    for (int v = 0; v < 2; v++) begin
      do_reset();
      max_instr = 64'd4;
      set_port(0, NOP, 64'h2000, 8'd0);
      set_port(1, NOP, 64'h2004, 8'd0);
      tick;
      clear_commit();
      chk("t3.early", 64'(d0_ht), 64'd0);
      set_port(0, NOP, 64'h2008, 8'd0);
      set_port(1, (v == 0) ? NOP : TRAP, 64'h200c, 8'd0);
      tick;
      clear_commit();
      chk("t3.hasTrap", 64'(d0_ht), 64'd1);
      chk("t3.code", 64'(d0_code), (v == 0) ? 64'd3 : 64'd0);
      chk("t3.instrCnt", d0_ins, 64'd4);
      chk("t3.pc", d0_pc, 64'h200c);
      max_instr = '0;
    end

    // 4: stall timeout, then with 20 WFI cycles inserted
    do_reset();
    set_port(0, NOP, 64'h1000, 8'd0);
    tick;
    clear_commit();
    measure(0, 0, n);
    chk("t4.delay", 64'(n), 64'd8);
    chk("t4.code", 64'(d1_code), 64'd2);
    chk("t4.pc", d1_pc, 64'h1000);
    do_reset();
    set_port(0, NOP, 64'h1000, 8'd0);
    tick;
    clear_commit();
    measure(2, 22, n);
    chk("t4.wfi_delay", 64'(n), 64'd28);
    chk("t4.wfi_code", 64'(d1_code), 64'd2);

    // 5: asynchronous reset with d1 halted and d0 running
    repeat (3) tick;
    #2 reset = 1'b1;
    #1 check_zero("t5.async");
    tick;
    reset = 1'b0;
    repeat (3) tick;
    chk("t5.restart_cyc", d0_cyc, 64'd3);
    set_port(0, TRAP, 64'h4000, 8'd0);
    a0_value = 64'd1;
    tick;
    clear_commit();
    chk("t5.retrap", 64'(d0_ht), 64'd1);
    chk("t5.code", 64'(d0_code), 64'd1);
    chk("t5.cyc", d0_cyc, 64'd4);

    // 6: instrCnt wraps with the limit disabled
    do_reset();
    repeat (2) tick;
    force dut.instr_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    m_ins[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.instr_cnt;
    set_port(0, NOP, 64'h5000, 8'd0);
    set_port(1, NOP, 64'h5004, 8'd0);
    set_port(2, NOP, 64'h5008, 8'd0);
    tick;
    clear_commit();
    chk("t6.wrap", d0_ins, 64'd1);
    chk("t6.no_trap", 64'(d0_ht), 64'd0);
    tick;
    chk("t6.no_trap2", 64'(d0_ht), 64'd0);

    cmp_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
